// File: rtl/contexto_pkg.sv
// Shared definitions for the context-switch sequencer: default sizing,
// FSM state encoding and the partition base-address helper.
package contexto_pkg;

    localparam int PROG_WIDTH   = 3;
    localparam int NUM_PROGRAMS = 8;
    localparam int BASE_STRIDE  = 1000;

    typedef enum logic [2:0] {
        IDLE,
        SALVA,
        CARREGA,
        LEITURA,
        PRONTO
    } estado_t;

    // Absolute base address of program p's partition. Callers truncate the
    // 64-bit product to their own data width.
    function automatic logic [63:0] base_programa(
        input logic [31:0] p,
        input logic [31:0] stride = 32'(BASE_STRIDE)
    );
        return 64'(p) * 64'(stride);
    endfunction

endpackage

// File: rtl/mascara_iniciados.sv
// Started-program mask: one bit per program telling whether that program
// has ever been switched away from, meaning the RAM save slot holds a valid PC.
// Program 0 runs out of reset, so its bit starts set.
module mascara_iniciados #(
    parameter int NUM_PROGRAMS = contexto_pkg::NUM_PROGRAMS,
    parameter int PROG_WIDTH   = contexto_pkg::PROG_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  marca_en,
    input  logic [PROG_WIDTH-1:0] marca_idx,
    input  logic [PROG_WIDTH-1:0] consulta_idx,
    output logic                  consulta_iniciado
);

    logic [NUM_PROGRAMS-1:0] iniciados;

    // Bits are only ever set; reset is the only way to clear them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iniciados <= NUM_PROGRAMS'(1);
        end else if (marca_en) begin
            for (int i = 0; i < NUM_PROGRAMS; i++) begin
                if (marca_idx == PROG_WIDTH'(i)) begin
                    iniciados[i] <= 1'b1;
                end
            end
        end
    end

    // Query port; indices outside the mask read as "not started".
    always_comb begin
        // NOTE: default assignment first so no path leaves the output unassigned (no latch).
        consulta_iniciado = 1'b0;
        for (int i = 0; i < NUM_PROGRAMS; i++) begin
            if (consulta_idx == PROG_WIDTH'(i)) begin
                consulta_iniciado = iniciados[i];
            end
        end
    end

endmodule

// File: rtl/troca_contexto.sv
// Context-switch sequencer between the control unit and the data RAM.
// Saves the running PC, moves the partition select to the destination
// program, then restores that program's PC (or its partition base on first
// entry) and hands the control unit an absolute resume PC.
module troca_contexto #(
    parameter int DATA_WIDTH   = 32,
    parameter int PROG_WIDTH   = contexto_pkg::PROG_WIDTH,
    parameter int NUM_PROGRAMS = contexto_pkg::NUM_PROGRAMS,
    parameter int BASE_STRIDE  = contexto_pkg::BASE_STRIDE
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  troca_req,
    input  logic [PROG_WIDTH-1:0] prog_destino,
    input  logic [DATA_WIDTH-1:0] pc_atual,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  ram_spc,
    output logic                  ram_lpc,
    output logic [DATA_WIDTH-1:0] ram_endereco_spc,
    output logic [PROG_WIDTH-1:0] programa,
    output logic [DATA_WIDTH-1:0] pc_novo,
    output logic                  pc_valido,
    output logic                  ocupado,
    output logic                  erro_prog
);

    import contexto_pkg::*;

    estado_t               estado;
    logic [PROG_WIDTH-1:0] destino;
    logic                  destino_iniciado;
    logic                  destino_ok;

    // Partition base for program p, truncated to the data width.
    function automatic logic [DATA_WIDTH-1:0] base_de(input logic [PROG_WIDTH-1:0] p);
        return DATA_WIDTH'(base_programa(32'(p), 32'(BASE_STRIDE)));
    endfunction

    assign destino_ok = 32'(prog_destino) < 32'(NUM_PROGRAMS);

    // The old program is marked started on the save cycle, while programa
    // still holds its number; the destination is queried in the same cycle.
    mascara_iniciados #(
        .NUM_PROGRAMS (NUM_PROGRAMS),
        .PROG_WIDTH   (PROG_WIDTH)
    ) u_mascara (
        .clock             (clock),
        .reset_n           (reset_n),
        .marca_en          (estado == SALVA),
        .marca_idx         (programa),
        .consulta_idx      (destino),
        .consulta_iniciado (destino_iniciado)
    );

    // Sequencer FSM with registered strobes, pulses and datapath latches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado           <= IDLE;
            destino          <= '0;
            ram_endereco_spc <= '0;
            programa         <= '0;
            pc_novo          <= '0;
            ram_spc          <= 1'b0;
            ram_lpc          <= 1'b0;
            pc_valido        <= 1'b0;
            erro_prog        <= 1'b0;
            ocupado          <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make every strobe a one-cycle pulse unless a state re-asserts it.
            ram_spc   <= 1'b0;
            ram_lpc   <= 1'b0;
            pc_valido <= 1'b0;
            erro_prog <= 1'b0;
            unique case (estado)
                IDLE: begin
                    ocupado <= 1'b0;
                    if (troca_req) begin
                        destino          <= prog_destino;
                        ram_endereco_spc <= pc_atual;
                        if (!destino_ok) begin
                            erro_prog <= 1'b1;
                        end else if (prog_destino == programa) begin
                            pc_novo   <= pc_atual;
                            pc_valido <= 1'b1;
                        end else begin
                            ram_spc <= 1'b1;
                            ocupado <= 1'b1;
                            estado  <= SALVA;
                        end
                    end
                end
                SALVA: begin
                    programa <= destino;
                    if (!destino_iniciado) begin
                        // First entry: nothing saved yet, resume at the partition base.
                        pc_novo   <= base_de(destino);
                        pc_valido <= 1'b1;
                        estado    <= PRONTO;
                    end else begin
                        ram_lpc <= 1'b1;
                        estado  <= CARREGA;
                    end
                end
                CARREGA: begin
                    estado <= LEITURA;
                end
                LEITURA: begin
                    pc_novo   <= ram_q + base_de(programa);
                    pc_valido <= 1'b1;
                    estado    <= PRONTO;
                end
                PRONTO: begin
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
                default: begin
                    ocupado <= 1'b0;
                    estado  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_troca_contexto.sv
// Self-checking bench for troca_contexto. A transaction-level model tracks
// the active program, which programs have been started and each program's
// saved relative PC, and predicts strobe timing and resume PC per switch.
module tb_troca_contexto;

    localparam int DW     = 32;
    localparam int PW     = 4;
    localparam int NP     = 8;
    localparam int STRIDE = 1000;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          troca_req = 1'b0;
    logic [PW-1:0] prog_destino = '0;
    logic [DW-1:0] pc_atual = '0;
    logic [DW-1:0] ram_q = '0;
    logic          ram_spc, ram_lpc, pc_valido, ocupado, erro_prog;
    logic [DW-1:0] ram_endereco_spc, pc_novo;
    logic [PW-1:0] programa;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level reference state.
    int            m_prog;
    bit            m_started [16];
    logic [DW-1:0] m_ram [16];

    // Behavioural data RAM: the save slot stores the PC relative to the
    // partition base; a load presents it on q the cycle after the strobe.
    logic [DW-1:0] mem [16];

    troca_contexto #(
        .DATA_WIDTH   (DW),
        .PROG_WIDTH   (PW),
        .NUM_PROGRAMS (NP),
        .BASE_STRIDE  (STRIDE)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .troca_req        (troca_req),
        .prog_destino     (prog_destino),
        .pc_atual         (pc_atual),
        .ram_q            (ram_q),
        .ram_spc          (ram_spc),
        .ram_lpc          (ram_lpc),
        .ram_endereco_spc (ram_endereco_spc),
        .programa         (programa),
        .pc_novo          (pc_novo),
        .pc_valido        (pc_valido),
        .ocupado          (ocupado),
        .erro_prog        (erro_prog)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_spc) mem[programa] <= ram_endereco_spc - 32'(programa) * 32'(STRIDE);
        if (ram_lpc) ram_q <= mem[programa];
    end

    task automatic model_reset();
        m_prog = 0;
        for (int i = 0; i < 16; i++) m_started[i] = 1'b0;
        m_started[0] = 1'b1;
    endtask

    // Issue one request and watch seven cycles after the accept edge.
    // With noise set, extra requests are driven while the switch is busy.
    task automatic run_switch(input logic [PW-1:0] dest, input logic [DW-1:0] pc,
                              input bit noise, input string tag);
        int exp_spc = 0, exp_lpc = 0, exp_valid = 0, exp_err = 0, lat;
        logic [DW-1:0] exp_pc = '0;
        int spc_c = 0, lpc_c = 0, val_c = 0, err_c = 0;
        int n_spc = 0, n_lpc = 0, n_val = 0, n_err = 0;
        logic [DW-1:0] got_pc = '0, got_end = '0;
        bit ocup_bad = 0, overlap = 0;
        int ocup_bad_c = 0;

        if (int'(dest) >= NP) begin
            exp_err = 1;
        end else if (int'(dest) == m_prog) begin
            exp_valid = 1;
            exp_pc    = pc;
        end else begin
            exp_spc = 1;
            m_ram[m_prog]     = pc - 32'(m_prog * STRIDE);
            m_started[m_prog] = 1'b1;
            if (m_started[dest]) begin
                exp_lpc   = 2;
                exp_valid = 4;
                exp_pc    = m_ram[dest] + 32'(int'(dest) * STRIDE);
            end else begin
                exp_valid = 2;
                exp_pc    = 32'(int'(dest) * STRIDE);
            end
            m_prog = int'(dest);
        end
        lat = (exp_spc != 0) ? exp_valid : 0;
        if (exp_spc == 0) noise = 0;

        @(negedge clock);
        troca_req    = 1'b1;
        prog_destino = dest;
        pc_atual     = pc;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            if (ram_spc) begin n_spc++; if (spc_c == 0) spc_c = c; got_end = ram_endereco_spc; end
            if (ram_lpc) begin n_lpc++; if (lpc_c == 0) lpc_c = c; end
            if (pc_valido) begin n_val++; if (val_c == 0) val_c = c; got_pc = pc_novo; end
            if (erro_prog) begin n_err++; if (err_c == 0) err_c = c; end
            if (ram_spc && ram_lpc) overlap = 1;
            if (ocupado !== (c <= lat)) begin ocup_bad = 1; if (ocup_bad_c == 0) ocup_bad_c = c; end
            if (noise && c <= 2) begin
                troca_req    = 1'b1;
                prog_destino = PW'($urandom_range(0, NP - 1));
                pc_atual     = $urandom;
            end else begin
                troca_req = 1'b0;
            end
        end

        n_checks++;
        if (spc_c != exp_spc || n_spc != (exp_spc != 0 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s ram_spc: got cycle %0d count %0d, want cycle %0d", tag, spc_c, n_spc, exp_spc);
        end
        if (exp_spc != 0) begin
            n_checks++;
            if (got_end !== pc) begin
                n_fail++;
                $display("FAIL %s ram_endereco_spc: got %0d, want %0d", tag, got_end, pc);
            end
        end
        n_checks++;
        if (lpc_c != exp_lpc || n_lpc != (exp_lpc != 0 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s ram_lpc: got cycle %0d count %0d, want cycle %0d", tag, lpc_c, n_lpc, exp_lpc);
        end
        n_checks++;
        if (val_c != exp_valid || n_val != (exp_valid != 0 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s pc_valido: got cycle %0d count %0d, want cycle %0d", tag, val_c, n_val, exp_valid);
        end
        if (exp_valid != 0) begin
            n_checks++;
            if (got_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL %s pc_novo: got %0d, want %0d", tag, got_pc, exp_pc);
            end
        end
        n_checks++;
        if (err_c != exp_err || n_err != exp_err) begin
            n_fail++;
            $display("FAIL %s erro_prog: got cycle %0d count %0d, want cycle %0d", tag, err_c, n_err, exp_err);
        end
        n_checks++;
        if (ocup_bad || overlap) begin
            n_fail++;
            $display("FAIL %s ocupado/overlap: ocupado wrong from cycle %0d, overlap %0d, want busy cycles 1..%0d",
                     tag, ocup_bad_c, overlap, lat);
        end
        n_checks++;
        if (int'(programa) != m_prog) begin
            n_fail++;
            $display("FAIL %s programa: got %0d, want %0d", tag, programa, m_prog);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_checks++;
        if (programa !== '0 || pc_novo !== '0 || ocupado !== 1'b0 || pc_valido !== 1'b0 ||
            ram_spc !== 1'b0 || ram_lpc !== 1'b0 || erro_prog !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got programa=%0d pc_novo=%0d ocupado=%0b pc_valido=%0b spc=%0b lpc=%0b erro=%0b, want all 0",
                     tag, programa, pc_novo, ocupado, pc_valido, ram_spc, ram_lpc, erro_prog);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset_held");
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        check_reset_values("reset_released");
    endtask

    task automatic test_first_entry();
        run_switch(4'd2, 32'd1017, 1'b0, "first_entry");
    endtask

    task automatic test_return();
        run_switch(4'd0, 32'd2005, 1'b0, "return_switch");
        run_switch(4'd2, 32'd0042, 1'b0, "back_to_2");
    endtask

    task automatic test_same_program();
        run_switch(4'd2, 32'd2040, 1'b0, "same_program");
    endtask

    task automatic test_invalid();
        run_switch(4'd8, 32'd2050, 1'b0, "invalid_8");
        run_switch(PW'($urandom_range(9, 15)), $urandom, 1'b0, "invalid_rand");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [PW-1:0] d;
            d = PW'($urandom_range(0, 10));
            run_switch(d, 32'(m_prog * STRIDE) + 32'($urandom_range(0, 999)), 1'b1, "random");
        end
    endtask

    task automatic test_reset_mid();
        if (m_prog == 0) run_switch(4'd3, 32'd0777, 1'b0, "pre_mid_reset");
        // Program 0 is always started, so this switch goes through CARREGA.
        @(negedge clock);
        troca_req    = 1'b1;
        prog_destino = '0;
        pc_atual     = 32'(m_prog * STRIDE) + 32'd11;
        @(negedge clock);
        troca_req = 1'b0;
        @(negedge clock);
        n_checks++;
        if (ram_lpc !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_lpc: got ram_lpc=%0b, want 1", ram_lpc);
        end
        #1 reset_n = 1'b0;
        #1 check_reset_values("mid_reset_async");
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        run_switch(4'd1, 32'd0123, 1'b0, "after_mid_reset");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]   = '0;
            m_ram[i] = '0;
        end
        model_reset();
        test_reset();
        test_first_entry();
        test_return();
        test_same_program();
        test_invalid();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
